// File: rtl/gpio_irq.sv
// gpio_irq: general-purpose IO block with per-pin edge interrupts.
//
// Each pin can be driven from OUT (when DIR=1) or left high-Z. All pins go through an
// input synchroniser. The synchronised value feeds IN and an edge detector that sets
// write-one-to-clear interrupt flags.
//
// Ports
//   clk        rising-edge clock
//   n_reset    asynchronous active-low reset
//   sel        peripheral select
//   pbus_addr  register address (word index 0..9)
//   pbus_we    write enable; writes land on the clock edge with sel=1 and pbus_we=1
//   pbus_data  bidirectional data; driven with read data only while sel=1, pbus_we=0
//   io         pins; bit i driven with OUT[i] when DIR[i]=1, otherwise high-Z
//   iodir      copy of DIR
//   irq        |(IFLAG & IEN)
//
// Register map (pbus_addr)
//   0 DIR rw, 1 OUT rw, 2 IN ro, 3 OUTSET wo, 4 OUTCLR wo, 5 OUTTGL wo,
//   6 IEN rw, 7 IPOL rw (1=rising), 8 IBOTH rw (1=both edges), 9 IFLAG r/w1c

`ifndef DATA_N
`define DATA_N 32
`endif

module gpio_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 sel,
  input  logic [3:0]           pbus_addr,
  input  logic                 pbus_we,
  inout  wire  [`DATA_N-1:0]   pbus_data,
  inout  wire  [WIDTH-1:0]     io,
  output logic [WIDTH-1:0]     iodir,
  output logic                 irq
);

  localparam int unsigned DataN = `DATA_N;

  localparam logic [3:0] AddrDir    = 4'h0;
  localparam logic [3:0] AddrOut    = 4'h1;
  localparam logic [3:0] AddrIn     = 4'h2;
  localparam logic [3:0] AddrOutSet = 4'h3;
  localparam logic [3:0] AddrOutClr = 4'h4;
  localparam logic [3:0] AddrOutTgl = 4'h5;
  localparam logic [3:0] AddrIen    = 4'h6;
  localparam logic [3:0] AddrIpol   = 4'h7;
  localparam logic [3:0] AddrIboth  = 4'h8;
  localparam logic [3:0] AddrIflag  = 4'h9;

  // Register state
  logic [WIDTH-1:0] dir_q,   dir_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] ien_q,   ien_d;
  logic [WIDTH-1:0] ipol_q,  ipol_d;
  logic [WIDTH-1:0] iboth_q, iboth_d;
  logic [WIDTH-1:0] iflag_q, iflag_d;

  // Input path
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] flag_set;

  // Bus path
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c_mask;
  logic [DataN-1:0] rdata;
  logic             unused_wdata;

  assign wr_en = sel & pbus_we;
  // Reset gating keeps the bus released while the block is held in reset.
  assign rd_en = sel & ~pbus_we & n_reset;
  assign wdata = pbus_data[WIDTH-1:0];
  // Data bits above WIDTH are deliberately ignored on writes.
  assign unused_wdata = ^pbus_data;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detection. Edges are taken from the synchronised value
  // of every pin, so pins configured as outputs loop back and can interrupt too.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= io;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pin_sync = sync_q[SYNC_STAGES-1];
  assign rise     = pin_sync & ~prev_q;
  assign fall     = ~pin_sync & prev_q;

  // IBOTH overrides IPOL; IPOL selects rising (1) or falling (0).
  assign edge_hit = (iboth_q & (rise | fall))
                  | (~iboth_q & ipol_q & rise)
                  | (~iboth_q & ~ipol_q & fall);
  assign flag_set = ien_q & edge_hit;

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    dir_d    = dir_q;
    out_d    = out_q;
    ien_d    = ien_q;
    ipol_d   = ipol_q;
    iboth_d  = iboth_q;
    w1c_mask = '0;

    if (wr_en) begin
      case (pbus_addr)
        AddrDir:    dir_d    = wdata;
        AddrOut:    out_d    = wdata;
        AddrOutSet: out_d    = out_q | wdata;
        AddrOutClr: out_d    = out_q & ~wdata;
        AddrOutTgl: out_d    = out_q ^ wdata;
        AddrIen:    ien_d    = wdata;
        AddrIpol:   ipol_d   = wdata;
        AddrIboth:  iboth_d  = wdata;
        AddrIflag:  w1c_mask = wdata;
        default:    ;
      endcase
    end

    // A new qualifying edge wins over a clear landing on the same bit.
    iflag_d = (iflag_q & ~w1c_mask) | flag_set;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dir_q   <= '0;
      out_q   <= '0;
      ien_q   <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      iflag_q <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      ien_q   <= ien_d;
      ipol_q  <= ipol_d;
      iboth_q <= iboth_d;
      iflag_q <= iflag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: write-only and unmapped addresses, and bits above WIDTH, read 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (pbus_addr)
      AddrDir:   rdata[WIDTH-1:0] = dir_q;
      AddrOut:   rdata[WIDTH-1:0] = out_q;
      AddrIn:    rdata[WIDTH-1:0] = pin_sync;
      AddrIen:   rdata[WIDTH-1:0] = ien_q;
      AddrIpol:  rdata[WIDTH-1:0] = ipol_q;
      AddrIboth: rdata[WIDTH-1:0] = iboth_q;
      AddrIflag: rdata[WIDTH-1:0] = iflag_q;
      default:   rdata = '0;
    endcase
  end

  assign pbus_data = rd_en ? rdata : {DataN{1'bz}};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign iodir = dir_q;
  // Pure function of flops, so it cannot glitch mid-cycle on input activity.
  assign irq   = |(iflag_q & ien_q);

endmodule
